// File: rtl/alu_share_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : alu_share_arbiter
//  Description : Round-robin sharing of one combinational ALU between two
//                requesters, with registered operands and registered results.
//  Revision    : 1.0  initial release
// ============================================================================
module alu_share_arbiter #(
  parameter int             W      = 32,
  parameter int             OPW    = 4,
  parameter logic [OPW-1:0] DIV_OP = 4'b0011,
  parameter logic [OPW-1:0] MAX_OP = 4'b1110
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           req0_valid,
  output logic           req0_ready,
  input  logic [OPW-1:0] req0_op,
  input  logic [W-1:0]   req0_a,
  input  logic [W-1:0]   req0_b,
  output logic           resp0_valid,
  output logic [W-1:0]   resp0_data,
  output logic           resp0_err,
  input  logic           req1_valid,
  output logic           req1_ready,
  input  logic [OPW-1:0] req1_op,
  input  logic [W-1:0]   req1_a,
  input  logic [W-1:0]   req1_b,
  output logic           resp1_valid,
  output logic [W-1:0]   resp1_data,
  output logic           resp1_err,
  output logic [OPW-1:0] alu_control,
  output logic [W-1:0]   alu_src_a,
  output logic [W-1:0]   alu_src_b,
  input  logic [W-1:0]   alu_result,
  output logic           busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t         r_state;
  logic           r_lastGrant;
  logic           r_owner;
  logic           r_busy;
  logic [OPW-1:0] r_aluControl;
  logic [W-1:0]   r_aluSrcA;
  logic [W-1:0]   r_aluSrcB;
  logic           r_resp0Valid;
  logic           r_resp1Valid;
  logic [W-1:0]   r_resp0Data;
  logic [W-1:0]   r_resp1Data;
  logic           r_resp0Err;
  logic           r_resp1Err;

  logic           w_grant;
  logic           w_accept;
  logic           w_err;
  logic [W-1:0]   w_respData;

  // Under contention the port that did not win last time is served.
  always_comb begin
    w_grant = 1'b0;
    if (req0_valid && req1_valid) begin
      w_grant = ~r_lastGrant;
    end else if (req1_valid) begin
      w_grant = 1'b1;
    end
  end

  assign w_accept   = (r_state == S_IDLE) && !rst && (req0_valid || req1_valid);
  assign req0_ready = w_accept && !w_grant;
  assign req1_ready = w_accept && w_grant;

  assign w_err      = (r_aluControl > MAX_OP) ||
                      ((r_aluControl == DIV_OP) && (r_aluSrcB == '0));
  assign w_respData = w_err ? {W{1'b1}} : alu_result;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_lastGrant  <= 1'b1;
      r_owner      <= 1'b0;
      r_busy       <= 1'b0;
      r_aluControl <= '0;
      r_aluSrcA    <= '0;
      r_aluSrcB    <= '0;
      r_resp0Valid <= 1'b0;
      r_resp1Valid <= 1'b0;
      r_resp0Data  <= '0;
      r_resp1Data  <= '0;
      r_resp0Err   <= 1'b0;
      r_resp1Err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_resp0Valid <= 1'b0;
          r_resp1Valid <= 1'b0;
          if (w_accept) begin
            r_aluControl <= w_grant ? req1_op : req0_op;
            r_aluSrcA    <= w_grant ? req1_a  : req0_a;
            r_aluSrcB    <= w_grant ? req1_b  : req0_b;
            r_owner      <= w_grant;
            r_lastGrant  <= w_grant;
            r_busy       <= 1'b1;
            r_state      <= S_EXEC;
          end
        end
        S_EXEC: begin
          // Only the owner's result registers change; the other port keeps its last result.
          if (r_owner) begin
            r_resp1Data  <= w_respData;
            r_resp1Err   <= w_err;
            r_resp1Valid <= 1'b1;
          end else begin
            r_resp0Data  <= w_respData;
            r_resp0Err   <= w_err;
            r_resp0Valid <= 1'b1;
          end
          r_state <= S_RESP;
        end
        S_RESP: begin
          r_resp0Valid <= 1'b0;
          r_resp1Valid <= 1'b0;
          r_busy       <= 1'b0;
          r_state      <= S_IDLE;
        end
        default: begin
          r_resp0Valid <= 1'b0;
          r_resp1Valid <= 1'b0;
          r_busy       <= 1'b0;
          r_state      <= S_IDLE;
        end
      endcase
    end
  end

  assign resp0_valid = r_resp0Valid;
  assign resp0_data  = r_resp0Data;
  assign resp0_err   = r_resp0Err;
  assign resp1_valid = r_resp1Valid;
  assign resp1_data  = r_resp1Data;
  assign resp1_err   = r_resp1Err;
  assign alu_control = r_aluControl;
  assign alu_src_a   = r_aluSrcA;
  assign alu_src_b   = r_aluSrcB;
  assign busy        = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_alu_share_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_share_arbiter
//  Description : Directed self-checking bench for alu_share_arbiter.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_alu_share_arbiter;

  localparam logic [3:0] c_OpAdd = 4'b0000;
  localparam logic [3:0] c_OpSub = 4'b0001;
  localparam logic [3:0] c_OpAnd = 4'b0010;
  localparam logic [3:0] c_OpDiv = 4'b0011;
  localparam logic [3:0] c_OpXor = 4'b0100;
  localparam logic [3:0] c_OpSlt = 4'b0101;

  logic        clk;
  logic        rst;
  logic        req0Valid, req0Ready, req1Valid, req1Ready;
  logic [3:0]  req0Op, req1Op, aluControl;
  logic [31:0] req0A, req0B, req1A, req1B;
  logic        resp0Valid, resp0Err, resp1Valid, resp1Err, busy;
  logic [31:0] resp0Data, resp1Data, aluSrcA, aluSrcB, aluResult;

  int numChecks = 0;
  int numErrors = 0;

  alu_share_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0Valid),
    .req0_ready (req0Ready),
    .req0_op    (req0Op),
    .req0_a     (req0A),
    .req0_b     (req0B),
    .resp0_valid(resp0Valid),
    .resp0_data (resp0Data),
    .resp0_err  (resp0Err),
    .req1_valid (req1Valid),
    .req1_ready (req1Ready),
    .req1_op    (req1Op),
    .req1_a     (req1A),
    .req1_b     (req1B),
    .resp1_valid(resp1Valid),
    .resp1_data (resp1Data),
    .resp1_err  (resp1Err),
    .alu_control(aluControl),
    .alu_src_a  (aluSrcA),
    .alu_src_b  (aluSrcB),
    .alu_result (aluResult),
    .busy       (busy)
  );

  // Reference combinational ALU; a zero divide returns a marker value the arbiter must mask.
  always_comb begin
    aluResult = 32'h0;
    case (aluControl)
      c_OpAdd: aluResult = aluSrcA + aluSrcB;
      c_OpSub: aluResult = aluSrcA - aluSrcB;
      c_OpAnd: aluResult = aluSrcA & aluSrcB;
      c_OpDiv: aluResult = (aluSrcB == 32'h0) ? 32'hDEADBEEF : aluSrcA / aluSrcB;
      c_OpXor: aluResult = aluSrcA ^ aluSrcB;
      c_OpSlt: aluResult = {31'h0, $signed(aluSrcA) < $signed(aluSrcB)};
      default: aluResult = 32'h0;
    endcase
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, required to finish");
    $fatal(1, "timeout");
  end

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    numChecks++;
    if (obs !== exp) begin
      numErrors++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clearReqs();
    req0Valid = 1'b0; req1Valid = 1'b0;
  endtask

  task automatic doReset();
    rst = 1'b1;
    clearReqs();
    step();
    step();
    rst = 1'b0;
    #1;
  endtask

  task automatic checkAllZero(input string tag);
    checkVal({tag, " ready0"}, {31'h0, req0Ready}, 32'h0);
    checkVal({tag, " ready1"}, {31'h0, req1Ready}, 32'h0);
    checkVal({tag, " rvalid"}, {30'h0, resp1Valid, resp0Valid}, 32'h0);
    checkVal({tag, " rdata0"}, resp0Data, 32'h0);
    checkVal({tag, " rdata1"}, resp1Data, 32'h0);
    checkVal({tag, " rerr"},   {30'h0, resp1Err, resp0Err}, 32'h0);
    checkVal({tag, " aluctl"}, {28'h0, aluControl}, 32'h0);
    checkVal({tag, " alua"},   aluSrcA, 32'h0);
    checkVal({tag, " alub"},   aluSrcB, 32'h0);
    checkVal({tag, " busy"},   {31'h0, busy}, 32'h0);
  endtask

  // One isolated request on a port, checked from request to response.
  task automatic doOp(input string tag, input bit port, input logic [3:0] op,
                      input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] expData, input bit expErr);
    if (port) begin
      req1Valid = 1'b1; req1Op = op; req1A = a; req1B = b;
    end else begin
      req0Valid = 1'b1; req0Op = op; req0A = a; req0B = b;
    end
    #1;
    checkVal({tag, " ready"}, {30'h0, req1Ready, req0Ready}, port ? 32'h2 : 32'h1);
    step();
    clearReqs();
    step();
    checkVal({tag, " rvalid"}, {30'h0, resp1Valid, resp0Valid}, port ? 32'h2 : 32'h1);
    checkVal({tag, " data"}, port ? resp1Data : resp0Data, expData);
    checkVal({tag, " err"}, {31'h0, port ? resp1Err : resp0Err}, {31'h0, expErr});
    step();
  endtask

  initial begin
    rst = 1'b1;
    req0Valid = 1'b0; req0Op = '0; req0A = '0; req0B = '0;
    req1Valid = 1'b0; req1Op = '0; req1A = '0; req1B = '0;

    // Reset state
    doReset();
    checkAllZero("reset");

    // 1. Single op on port 0 with per-cycle latency checks
    req0Valid = 1'b1; req0Op = c_OpAdd; req0A = 32'd5; req0B = 32'd7;
    #1;
    checkVal("t1 c0 ready", {30'h0, req1Ready, req0Ready}, 32'h1);
    step();
    clearReqs();
    checkVal("t1 c1 busy", {31'h0, busy}, 32'h1);
    checkVal("t1 c1 rvalid", {30'h0, resp1Valid, resp0Valid}, 32'h0);
    checkVal("t1 c1 alua", aluSrcA, 32'd5);
    checkVal("t1 c1 alub", aluSrcB, 32'd7);
    checkVal("t1 c1 aluctl", {28'h0, aluControl}, {28'h0, c_OpAdd});
    step();
    checkVal("t1 c2 rvalid", {30'h0, resp1Valid, resp0Valid}, 32'h1);
    checkVal("t1 c2 data", resp0Data, 32'd12);
    checkVal("t1 c2 err", {31'h0, resp0Err}, 32'h0);
    step();
    checkVal("t1 c3 rvalid", {30'h0, resp1Valid, resp0Valid}, 32'h0);
    checkVal("t1 c3 busy", {31'h0, busy}, 32'h0);
    checkVal("t1 c3 hold data", resp0Data, 32'd12);
    checkVal("t1 c3 hold alua", aluSrcA, 32'd5);

    // 2/6. Contention from reset; port 1 held off while port 0 is in flight
    doReset();
    req0Valid = 1'b1; req0Op = c_OpSub; req0A = 32'd10;   req0B = 32'd3;
    req1Valid = 1'b1; req1Op = c_OpXor; req1A = 32'hF0;   req1B = 32'h0F;
    #1;
    checkVal("t2 c0 ready", {30'h0, req1Ready, req0Ready}, 32'h1);
    step();
    req0Valid = 1'b0;
    checkVal("t2 c1 ready1", {31'h0, req1Ready}, 32'h0);
    checkVal("t2 c1 alua", aluSrcA, 32'd10);
    checkVal("t2 c1 alub", aluSrcB, 32'd3);
    step();
    checkVal("t2 c2 ready1", {31'h0, req1Ready}, 32'h0);
    checkVal("t2 c2 rvalid", {30'h0, resp1Valid, resp0Valid}, 32'h1);
    checkVal("t2 c2 data0", resp0Data, 32'd7);
    step();
    checkVal("t2 c3 ready1", {31'h0, req1Ready}, 32'h1);
    step();
    req1Valid = 1'b0;
    checkVal("t2 c4 alua", aluSrcA, 32'hF0);
    step();
    checkVal("t2 c5 rvalid", {30'h0, resp1Valid, resp0Valid}, 32'h2);
    checkVal("t2 c5 data1", resp1Data, 32'hFF);
    checkVal("t2 c5 hold data0", resp0Data, 32'd7);
    step();

    // 3. Fairness: both held valid for 4 ops, last grant was port 1
    req0Valid = 1'b1; req0Op = c_OpAdd; req0A = 32'd1; req0B = 32'd1;
    req1Valid = 1'b1; req1Op = c_OpAnd; req1A = 32'hFF; req1B = 32'h0F;
    for (int i = 0; i < 4; i++) begin
      #1;
      checkVal($sformatf("t3 op%0d grant", i), {30'h0, req1Ready, req0Ready},
               (i % 2 == 0) ? 32'h1 : 32'h2);
      step();
      step();
      checkVal($sformatf("t3 op%0d rvalid", i), {30'h0, resp1Valid, resp0Valid},
               (i % 2 == 0) ? 32'h1 : 32'h2);
      checkVal($sformatf("t3 op%0d data", i), (i % 2 == 0) ? resp0Data : resp1Data,
               (i % 2 == 0) ? 32'd2 : 32'h0F);
      step();
    end
    clearReqs();

    // 4. Error detection and recovery
    doOp("t4 div0",  1'b0, c_OpDiv, 32'd100, 32'd0, 32'hFFFFFFFF, 1'b1);
    doOp("t4 op15",  1'b1, 4'b1111, 32'd4,   32'd2, 32'hFFFFFFFF, 1'b1);
    doOp("t4 add",   1'b0, c_OpAdd, 32'd1,   32'd2, 32'd3,        1'b0);
    doOp("t4 div",   1'b1, c_OpDiv, 32'd100, 32'd5, 32'd20,       1'b0);
    doOp("t4 slt",   1'b0, c_OpSlt, 32'hFFFFFFFF, 32'd1, 32'd1,   1'b0);
    doOp("t4 maxop", 1'b1, 4'b1110, 32'd9,   32'd9, 32'd0,        1'b0);

    // 5. Reset while in EXEC after a port 0 accept
    req0Valid = 1'b1; req0Op = c_OpAdd; req0A = 32'd20; req0B = 32'd22;
    #1;
    checkVal("t5 ready0", {31'h0, req0Ready}, 32'h1);
    step();
    clearReqs();
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    checkAllZero("t5 post-reset");
    step();
    checkVal("t5 no pulse", {30'h0, resp1Valid, resp0Valid}, 32'h0);
    req0Valid = 1'b1; req1Valid = 1'b1;
    #1;
    checkVal("t5 next grant", {30'h0, req1Ready, req0Ready}, 32'h1);
    step();
    clearReqs();
    step();
    step();

    $display("Simulation finished: %0d checks, %0d errors", numChecks, numErrors);
    $finish;
  end

endmodule
`default_nettype wire
